// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_REQ         = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        mem2reg;
        logic        wreg;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] rd_dmem;
    } wb_bus_t;

    localparam wb_bus_t WB_BUBBLE = '0;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatting: bring the addressed lane down to bit 0, then
// sign- or zero-extend to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic        [31:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    assign shifted   = rdata >> {offset, 3'b000};
    assign byte_s    = shifted[7:0];
    assign half_s    = shifted[15:0];
    assign byte_sext = 32'(byte_s);
    assign half_sext = 32'(half_s);

    always_comb begin
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'b0, shifted[7:0]}  : byte_sext;
            SZ_HALF: data = is_unsigned ? {16'b0, shifted[15:0]} : half_sext;
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding req/gnt/rvalid access to data
// memory, with writeback formatting toward the MEM/WB register.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_ex_valid,
    input  logic              i_ex_mem2reg,
    input  logic              i_ex_memwrite,
    input  logic              i_ex_wreg,
    input  logic [4:0]        i_ex_rd,
    input  logic [31:0]       i_ex_alu,
    input  logic [31:0]       i_ex_store_data,
    input  logic [1:0]        i_ex_size,
    input  logic              i_ex_unsigned,
    output logic              o_dmem_req,
    input  logic              i_dmem_gnt,
    output logic              o_dmem_we,
    output logic [3:0]        o_dmem_be,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata,
    input  logic              i_dmem_err,
    output logic              o_mem_mem2reg,
    output logic              o_mem_wreg,
    output logic [4:0]        o_mem_rd,
    output logic [31:0]       o_mem_data,
    output logic [31:0]       o_rd_dmem,
    output logic              o_stall,
    output logic              o_mem_err
);

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [4:0]        rd_q;
    logic              wreg_q;
    logic [31:0]       tcnt_q;

    logic              memop;
    logic              misaligned;
    logic              timeout_hit;
    logic [31:0]       load_data;
    wb_bus_t           wb;
    logic              stall;
    logic              err;

    assign memop       = i_ex_valid & (i_ex_mem2reg | i_ex_memwrite);
    assign misaligned  = is_misaligned(i_ex_size, i_ex_alu[1:0]);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tcnt_q == TO_LAST);

    lsu_load_align u_load_align (
        .rdata       (i_dmem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // Outputs are forced to a bubble while reset is held so nothing leaks
    // downstream from the combinational pass-through path.
    always_comb begin
        wb    = WB_BUBBLE;
        stall = 1'b0;
        err   = 1'b0;
        if (i_resetn) begin
            case (state_q)
                ST_IDLE: begin
                    if (!memop) begin
                        wb.wreg = i_ex_valid & i_ex_wreg;
                        wb.rd   = i_ex_rd;
                        wb.data = i_ex_alu;
                    end else if (misaligned) begin
                        err = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                ST_REQ: stall = 1'b1;
                ST_WAIT_RVALID: begin
                    if (i_dmem_rvalid) begin
                        if (i_dmem_err) begin
                            err = 1'b1;
                        end else if (!we_q) begin
                            wb.mem2reg = 1'b1;
                            wb.wreg    = wreg_q;
                            wb.rd      = rd_q;
                            wb.data    = load_data;
                            wb.rd_dmem = load_data;
                        end
                    end else if (timeout_hit) begin
                        err = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            wreg_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (memop && !misaligned) begin
                        we_q    <= i_ex_memwrite;
                        be_q    <= byte_enables(i_ex_size, i_ex_alu[1:0]);
                        addr_q  <= i_ex_alu[ADDR_W-1:0];
                        wdata_q <= store_lanes(i_ex_size, i_ex_store_data);
                        size_q  <= i_ex_size;
                        uns_q   <= i_ex_unsigned;
                        rd_q    <= i_ex_rd;
                        wreg_q  <= i_ex_wreg;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_dmem_gnt) begin
                        req_q   <= 1'b0;
                        tcnt_q  <= '0;
                        state_q <= ST_WAIT_RVALID;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (i_dmem_rvalid || timeout_hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_dmem_req    = req_q;
    assign o_dmem_we     = we_q;
    assign o_dmem_be     = be_q;
    assign o_dmem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_dmem_wdata  = wdata_q;
    assign o_mem_mem2reg = wb.mem2reg;
    assign o_mem_wreg    = wb.wreg;
    assign o_mem_rd      = wb.rd;
    assign o_mem_data    = wb.data;
    assign o_rd_dmem     = wb.rd_dmem;
    assign o_stall       = stall;
    assign o_mem_err     = err;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed cases plus randomized traffic
// against a lane-level reference model and a scripted memory responder.
module tb_mem_stage_lsu;

    localparam int TO   = 4;
    localparam int HOLD = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_m2r, ex_mw, ex_wreg, ex_uns;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu, ex_sd;
    logic [1:0]  ex_size;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid, dmem_err;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_m2r, mem_wreg, stall, mem_err;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data, rd_dmem;

    mem_stage_lsu #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .i_clk(clk), .i_resetn(rst_n),
        .i_ex_valid(ex_valid), .i_ex_mem2reg(ex_m2r), .i_ex_memwrite(ex_mw),
        .i_ex_wreg(ex_wreg), .i_ex_rd(ex_rd), .i_ex_alu(ex_alu),
        .i_ex_store_data(ex_sd), .i_ex_size(ex_size), .i_ex_unsigned(ex_uns),
        .o_dmem_req(dmem_req), .i_dmem_gnt(dmem_gnt), .o_dmem_we(dmem_we),
        .o_dmem_be(dmem_be), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata), .i_dmem_err(dmem_err),
        .o_mem_mem2reg(mem_m2r), .o_mem_wreg(mem_wreg), .o_mem_rd(mem_rd),
        .o_mem_data(mem_data), .o_rd_dmem(rd_dmem), .o_stall(stall), .o_mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem2reg;
        logic        wreg;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] rd_dmem;
        logic        err;
        bit          full;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic        err;
    } plan_t;

    exp_t  exp_q[$];
    req_t  req_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stray_req = 0;
    int    stray_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the access rules.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a[1:0]);
        return (sz == 2'd3) || ((off % nbytes(sz)) != 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = '0;
        int off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(sz));
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic uns, input logic [31:0] rdata);
        int n = nbytes(sz);
        logic [31:0] v = rdata >> (8 * int'(a[1:0]));
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = v & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic issue(input logic valid, input logic m2r, input logic mw, input logic wreg,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [1:0] sz, input logic uns, input plan_t p);
        exp_t e;
        req_t r;
        bit   timeout;
        int   n;
        logic [31:0] ld;
        @(posedge clk); #1;
        ex_valid = valid; ex_m2r = m2r; ex_mw = mw; ex_wreg = wreg; ex_rd = rd;
        ex_alu = alu; ex_sd = sd; ex_size = sz; ex_uns = uns;
        e = '{default: 0};
        if (!(valid && (m2r || mw))) begin
            e.wreg = valid && wreg; e.rd = rd; e.data = alu; e.full = 1;
        end else if (ref_misaligned(sz, alu)) begin
            e.err = 1; e.full = 1;
        end else begin
            r.we = mw; r.be = ref_be(sz, alu); r.addr = {alu[31:2], 2'b00};
            r.wdata = ref_wdata(sz, sd);
            req_q.push_back(r);
            plan_q.push_back(p);
            timeout  = !(p.rv_dly >= 1 && p.rv_dly <= TO);
            e.stalls = p.gnt_dly + (timeout ? TO : p.rv_dly) + 1;
            if (timeout || p.err) begin
                e.err = 1;
            end else if (!mw) begin
                ld = ref_load(sz, alu, uns, p.rdata);
                e.mem2reg = 1; e.wreg = wreg; e.rd = rd; e.data = ld; e.rd_dmem = ld; e.full = 1;
            end
        end
        if (valid) begin
            exp_q.push_back(e);
            n = 0;
            do begin @(negedge clk); n++; end while (stall && n < 64);
            if (n >= 64) begin
                checks++; errors++;
                $display("FAIL retire_wait: got stall after %0d cycles expected retire", n);
            end
        end else begin
            @(negedge clk);
        end
    endtask

    // Memory responder following the per-access plan queue.
    initial begin
        int    rs = 0, cnt = 0, wcnt = 0;
        plan_t cur;
        cur = '{default: 0};
        dmem_gnt = 0; dmem_rvalid = 0; dmem_err = 0; dmem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            dmem_gnt = 0; dmem_rvalid = 0; dmem_err = 0; dmem_rdata = $urandom;
            if (!rst_n) begin
                rs = 0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                dmem_rvalid = 1; dmem_err = 1'($urandom_range(0, 1));
            end else if (rs == 2) begin
                if (cur.rv_dly == wcnt) begin
                    dmem_rvalid = 1; dmem_rdata = cur.rdata; dmem_err = cur.err; rs = 0;
                end else if (wcnt == TO && cur.rv_dly != HOLD) begin
                    rs = 0;
                end
                wcnt++;
            end else begin
                if (rs == 0 && dmem_req) begin
                    if (plan_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unplanned_req: got req=1 expected no request");
                    end else begin
                        cur = plan_q.pop_front(); cnt = cur.gnt_dly; rs = 1;
                    end
                end
                if (rs == 1) begin
                    if (cnt == 0) begin dmem_gnt = 1; rs = 2; wcnt = 1; end
                    else cnt--;
                end
            end
        end
    end

    // Monitor: request check on handshake, writeback check on retire.
    initial begin
        int   scnt = 0;
        exp_t e;
        req_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                scnt = 0;
            end else begin
                if (dmem_req && dmem_gnt) begin
                    if (req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL req_unexpected: got addr 0x%08h expected none", dmem_addr);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_we", 32'(dmem_we), 32'(r.we));
                        chk("req_be", 32'(dmem_be), 32'(r.be));
                        chk("req_addr", dmem_addr, r.addr);
                        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
                    end
                end
                if (!ex_valid) begin
                    chk("idle_err", 32'(mem_err), 32'h0);
                end else if (stall) begin
                    scnt++;
                    chk("stall_bubble_ctl", {25'b0, mem_m2r, mem_wreg, mem_err, mem_rd}, 32'h0);
                    chk("stall_bubble_data", mem_data | rd_dmem, 32'h0);
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL retire_unexpected: got retire expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_stall_cycles", 32'(scnt), 32'(e.stalls));
                    chk("ret_err", 32'(mem_err), 32'(e.err));
                    chk("ret_mem2reg", 32'(mem_m2r), 32'(e.mem2reg));
                    chk("ret_wreg", 32'(mem_wreg), 32'(e.wreg));
                    chk("ret_dmem_req", 32'(dmem_req), 32'h0);
                    if (e.full) begin
                        chk("ret_rd", 32'(mem_rd), 32'(e.rd));
                        chk("ret_data", mem_data, e.data);
                        chk("ret_rd_dmem", rd_dmem, e.rd_dmem);
                    end
                    scnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        plan_t np;
        plan_t p;
        req_t  r;
        int    kind;
        np = '{gnt_dly: 0, rv_dly: 1, rdata: 32'h0, err: 1'b0};

        rst_n = 0;
        ex_valid = 1; ex_m2r = 0; ex_mw = 0; ex_wreg = 1; ex_rd = 5'd3;
        ex_alu = 32'hDEAD_BEEF; ex_sd = 32'h1111_2222; ex_size = 2'd2; ex_uns = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ctl", {22'b0, dmem_req, dmem_we, mem_m2r, mem_wreg, stall, mem_err, dmem_be}, 32'h0);
        chk("rst_rd", 32'(mem_rd), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_data", mem_data | rd_dmem, 32'h0);
        @(negedge clk);
        rst_n = 1; ex_valid = 0;

        issue(1, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 2'd2, 0, np);
        issue(1, 1, 0, 1, 5'd9, 32'h103, 32'h0, 2'd0, 0,
              '{gnt_dly: 2, rv_dly: 1, rdata: 32'h80FF_0000, err: 1'b0});
        issue(1, 0, 1, 1, 5'd10, 32'h202, 32'hABCD_1234, 2'd1, 0,
              '{gnt_dly: 0, rv_dly: 1, rdata: 32'h0, err: 1'b0});
        issue(1, 1, 0, 1, 5'd4, 32'h301, 32'h0, 2'd2, 0, np);
        issue(1, 1, 0, 1, 5'd6, 32'h4, 32'h0, 2'd1, 1,
              '{gnt_dly: 0, rv_dly: 1, rdata: 32'hFFFF_FFFF, err: 1'b1});
        issue(1, 1, 0, 1, 5'd7, 32'h8, 32'h0, 2'd2, 0,
              '{gnt_dly: 1, rv_dly: 0, rdata: 32'h0, err: 1'b0});
        issue(1, 1, 0, 1, 5'd8, 32'h6, 32'h0, 2'd1, 0,
              '{gnt_dly: 1, rv_dly: TO, rdata: 32'h8001_0000, err: 1'b0});
        issue(1, 0, 1, 0, 5'd1, 32'h10, 32'h5566_7788, 2'd3, 0, np);

        // Reset while waiting for rvalid, then a stray rvalid after release.
        p = '{gnt_dly: 0, rv_dly: HOLD, rdata: 32'h0, err: 1'b0};
        @(posedge clk); #1;
        ex_valid = 1; ex_m2r = 1; ex_mw = 0; ex_wreg = 1; ex_rd = 5'd7;
        ex_alu = 32'h40; ex_size = 2'd2; ex_uns = 0;
        r = '{we: 1'b0, be: 4'hF, addr: 32'h40, wdata: ex_sd};
        req_q.push_back(r);
        plan_q.push_back(p);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_stall", 32'(stall), 32'h1);
        rst_n = 0; ex_valid = 0;
        #1;
        chk("reset_req_drop", 32'(dmem_req), 32'h0);
        chk("reset_stall_drop", 32'(stall), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        stray_req++;
        @(posedge clk); #1;
        ex_valid = 0; ex_m2r = 1; ex_wreg = 1; ex_rd = 5'd2; ex_alu = 32'h55AA;
        @(negedge clk);
        chk("stray_rv_stall", 32'(stall), 32'h0);
        chk("stray_rv_mem2reg", 32'(mem_m2r), 32'h0);
        chk("stray_rv_wreg", 32'(mem_wreg), 32'h0);
        chk("stray_rv_data", mem_data, 32'h55AA);
        @(posedge clk); #1;
        chk("stray_rv_no_req", 32'(dmem_req), 32'h0);
        issue(1, 0, 0, 1, 5'd12, 32'hCAFE_0001, 32'h0, 2'd0, 0, np);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            p.gnt_dly = $urandom_range(0, 2);
            p.rv_dly  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
            p.rdata   = $urandom;
            p.err     = ($urandom_range(0, 7) == 0);
            issue(($urandom_range(0, 9) != 0), (kind == 1), (kind == 2), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), p);
        end

        @(posedge clk); #1;
        ex_valid = 0;
        repeat (5) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("req_q_drained", 32'(req_q.size()), 32'h0);
        chk("plan_q_drained", 32'(plan_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM instruction and runs a req/gnt/rvalid handshake to data memory. It formats store byte lanes and load data, and presents writeback control and data to MEM/WB. It stalls the front of the pipe while an access is outstanding and drives a bubble downstream meanwhile.

Parameters:
TIMEOUT_CYC, 255, max cycles in WAIT_RVALID before forced error completion; 0 disables the watchdog
ADDR_W, 32, data-memory address width

Ports:
i_clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_ex_valid  in  1  EX/MEM slot holds a real instruction
i_ex_mem2reg  in  1  instruction is a load
i_ex_memwrite  in  1  instruction is a store
i_ex_wreg  in  1  instruction writes rd
i_ex_rd  in  5  destination register
i_ex_alu  in  32  ALU result / effective address
i_ex_store_data  in  32  rs2 store data
i_ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved
i_ex_unsigned  in  1  zero-extend load
o_dmem_req  out  1  memory request
i_dmem_gnt  in  1  request accepted
o_dmem_we  out  1  write enable
o_dmem_be  out  4  byte enables
o_dmem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
o_dmem_wdata  out  32  lane-replicated store data
i_dmem_rvalid  in  1  response valid (loads and stores)
i_dmem_rdata  in  32  load data
i_dmem_err  in  1  bus error, qualified by rvalid
o_mem_mem2reg  out  1  to MEM/WB
o_mem_wreg  out  1  to MEM/WB
o_mem_rd  out  5  to MEM/WB
o_mem_data  out  32  to MEM/WB: ALU result, or formatted load data for loads
o_rd_dmem  out  32  to MEM/WB: formatted load data
o_stall  out  1  hold EX/MEM and earlier stages
o_mem_err  out  1  one-cycle error pulse (misaligned, bus error, timeout)

Behaviour:
- Reset (async, active-low): state IDLE, timeout counter 0, latched fields 0. All outputs 0. o_dmem_req drops immediately, mid-handshake included. A stale rvalid after reset is ignored because rvalid is ignored in IDLE.
- States: IDLE, REQ, WAIT_RVALID.
- Memop = i_ex_valid & (i_ex_mem2reg | i_ex_memwrite).
- Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- IDLE, non-memop: zero-latency combinational pass-through. mem2reg=0, wreg=i_ex_valid&i_ex_wreg, rd, data=i_ex_alu, o_rd_dmem=0, o_stall=0.
- IDLE, misaligned memop: no request is issued. o_mem_err=1 and a bubble goes downstream in the same cycle. o_stall=0, so the instruction retires.
- IDLE, aligned memop: latch addr/size/unsigned/we/rd/wreg/wdata, go to REQ. o_stall=1 in the same cycle; bubble downstream.
- REQ: o_dmem_req=1. addr/we/be/wdata come from the latched registers and stay stable until gnt. On gnt go to WAIT_RVALID (gnt may arrive in the first REQ cycle). o_stall=1; bubble.
- WAIT_RVALID: o_stall=1 and bubble until rvalid. rvalid one cycle after gnt is legal. When rvalid arrives:
  - state goes to IDLE and o_stall=0 in that cycle;
  - outputs combinationally present the completed instruction;
  - load: mem2reg=1, wreg=latched wreg, rd, o_mem_data=o_rd_dmem=formatted rdata;
  - store: mem2reg=0, wreg=0.
- Bus error on rvalid: wreg=0, mem2reg=0, o_mem_err=1.
- Timeout: counter increments each WAIT_RVALID cycle. Reaching TIMEOUT_CYC completes as a bus error, then the unit returns to IDLE.
- Bubble: mem2reg=0, wreg=0, rd=0, data=0, o_rd_dmem=0.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load format: shift rdata right by 8*addr[1:0], then take 8/16/32 bits. Sign-extend unless unsigned.
- Only one access is outstanding; no pipelined requests.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, bubble constant.
- Sub-module lsu_load_align: combinational rdata shift plus sign/zero extend (inputs rdata, offset, size, unsigned).

Test Plan:
- Non-memop with alu=0x1234, rd=5, wreg=1 -> same cycle mem_data=0x1234, rd=5, wreg=1, stall=0, no dmem_req.
- lb at 0x103, unsigned=0, gnt after 2 REQ cycles, rdata=0x80FF_0000 -> be=1000, addr=0x100, stall for 4 cycles, rd_dmem=0xFFFF_FF80, mem2reg=1.
- sh at 0x202, data=0xABCD_1234, gnt immediately -> be=1100, wdata=0x1234_1234, we=1, completion has wreg=0.
- lw at 0x301 -> no req, o_mem_err pulse, wreg=0, stall=0; lhu at 0x4 with rvalid+err -> err pulse, wreg=0.
- Reset asserted in WAIT_RVALID, then rvalid after release -> req/stall drop at once, stray rvalid ignored; TIMEOUT_CYC=4 without rvalid -> err on the 4th WAIT cycle, then IDLE.
